// File: rtl/debounce_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | debounce_pkg : shared timing defaults and width helper           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package debounce_pkg;

    // Defaults for a 100 MHz clock: 50 ms debounce, 1 s long press, 200 ms repeat
    localparam int unsigned DEF_DB_CYCLES     = 5_000_000;
    localparam int unsigned DEF_LONG_CYCLES   = 100_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 20_000_000;

    // ceil(log2(value)), never less than 1 so every counter has at least one bit
    function automatic int unsigned clog2w(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | debounce_channel : sync, debounce, strobes, long/repeat, 1 pin   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic n_reset,
    input  logic pin_i,
    output logic db_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned DBW      = clog2w(DB_CYCLES);
    localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW       = clog2w(HOLD_MAX + 1);
    localparam bit          REP_EN   = (REPEAT_CYCLES > 0);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0]  REP_LAST  = HW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

    logic [1:0]     sync_q,      sync_d;
    logic [DBW-1:0] db_cnt_q,    db_cnt_d;
    logic           db_q,        db_d;
    logic [HW-1:0]  hold_q,      hold_d;
    logic           long_done_q, long_done_d;
    logic           press_q,     press_d;
    logic           release_q,   release_d;
    logic           long_q,      long_d;
    logic           repeat_q,    repeat_d;
    logic           flip;

    always_comb begin
        sync_d      = {sync_q[0], pin_i};
        db_cnt_d    = '0;
        db_d        = db_q;
        flip        = 1'b0;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;

        if (sync_q[1] != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d = sync_q[1];
                flip = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // A level change outranks any hold threshold reached on the same edge
        if (flip) begin
            press_d     = ~db_q;
            release_d   = db_q;
            hold_d      = '0;
            long_done_d = 1'b0;
        end else if (db_q) begin
            if (!long_done_q) begin
                if (hold_q == LONG_LAST) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                    hold_d      = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end else if (REP_EN) begin
                if (hold_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    hold_d   = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_reset) begin
            sync_q      <= '0;
            db_cnt_q    <= '0;
            db_q        <= 1'b0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            db_cnt_q    <= db_cnt_d;
            db_q        <= db_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign db_o      = db_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | debounce_bank : multi-channel push-button conditioner            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned         CHANNELS      = 4,
    parameter int unsigned         DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned         LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned         REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW    = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_pressed
);

    generate
        if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_param_check
            $error("debounce_bank: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
        end
    endgenerate

    // Everything downstream of this XOR works on "1 = pressed"
    logic [CHANNELS-1:0] pin_logical;
    assign pin_logical = button_in ^ ACTIVE_LOW;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            debounce_channel #(
                .DB_CYCLES     (DB_CYCLES),
                .LONG_CYCLES   (LONG_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_chan (
                .clk       (clk),
                .n_reset   (n_reset),
                .pin_i     (pin_logical[i]),
                .db_o      (db_out[i]),
                .press_o   (press_pulse[i]),
                .release_o (release_pulse[i]),
                .long_o    (long_pulse[i]),
                .repeat_o  (repeat_pulse[i])
            );
        end
    endgenerate

    logic any_pressed_q;

    always_ff @(posedge clk) begin
        if (n_reset) begin
            any_pressed_q <= 1'b0;
        end else begin
            any_pressed_q <= |db_out;
        end
    end

    assign any_pressed = any_pressed_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_debounce_bank : table + scoreboard bench for debounce_bank    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_debounce_bank;

    localparam int         DB   = 8;
    localparam int         LONG = 32;
    localparam int         REP  = 8;
    localparam int         LAT  = DB + 1;
    localparam logic [3:0] AL   = 4'b0100;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] button_in;
    logic [3:0] db_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;
    logic [3:0] repeat_pulse;
    logic       any_pressed;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } exp_t;

    typedef struct {
        int ch;
        bit level;
        int hold;
        bit exp_long;
        int exp_reps;
    } vec_t;

    exp_t exp_q[$];

    debounce_bank #(
        .CHANNELS      (4),
        .DB_CYCLES     (DB),
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .ACTIVE_LOW    (AL)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .button_in     (button_in),
        .db_out        (db_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .any_pressed   (any_pressed)
    );

    always #5 clk = ~clk;

    // cyc == N after active edge N
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ekey(input exp_t e);
        return e.cyc * 64 + e.kind * 8 + e.ch;
    endfunction

    function automatic void push_exp(input int c, input int k, input int ch);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        idx    = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ekey(exp_q[i]) > ekey(e)) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, e);
    endfunction

    function automatic logic strobe_bit(input int k, input int ch);
        case (k)
            K_PRESS: return press_pulse[ch];
            K_REL:   return release_pulse[ch];
            K_LONG:  return long_pulse[ch];
            default: return repeat_pulse[ch];
        endcase
    endfunction

    // Scoreboard: every strobe seen must be the next expected event
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL strobe_missing: kind=%0d ch=%0d got no strobe, required at cycle %0d",
                         exp_q[0].kind, exp_q[0].ch, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            for (int k = 0; k < 4; k++) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (strobe_bit(k, ch) === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0 || exp_q[0].cyc != cyc ||
                            exp_q[0].kind != k || exp_q[0].ch != ch) begin
                            errors++;
                            $display("FAIL strobe_unexpected: got kind=%0d ch=%0d at cycle %0d, required no such strobe",
                                     k, ch, cyc);
                        end else begin
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic set_level(input int ch, input bit lvl);
        button_in[ch] = lvl ^ AL[ch];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_db"},      32'(db_out),        32'd0);
        check({tag, "_press"},   32'(press_pulse),   32'd0);
        check({tag, "_release"}, 32'(release_pulse), 32'd0);
        check({tag, "_long"},    32'(long_pulse),    32'd0);
        check({tag, "_repeat"},  32'(repeat_pulse),  32'd0);
        check({tag, "_any"},     32'(any_pressed),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   t;
        int   p;
        int   c;

        // {ch, logical level, hold cycles, long expected, repeat count}
        tbl[0] = '{0, 1'b1, 20, 1'b0, 0};   // clean press
        tbl[1] = '{0, 1'b0, 20, 1'b0, 0};
        tbl[2] = '{3, 1'b1, 60, 1'b1, 3};   // long at +32, repeats +40/+48/+56
        tbl[3] = '{3, 1'b0, 20, 1'b0, 0};
        tbl[4] = '{0, 1'b1, 32, 1'b0, 0};   // release lands on the long edge
        tbl[5] = '{0, 1'b0, 20, 1'b0, 0};
        tbl[6] = '{2, 1'b1, 40, 1'b1, 0};   // release lands on the first repeat edge
        tbl[7] = '{2, 1'b0, 20, 1'b0, 0};
        tbl[8] = '{1, 1'b1, 33, 1'b1, 0};   // release one cycle after long
        tbl[9] = '{1, 1'b0, 20, 1'b0, 0};

        n_reset   = 1'b1;
        button_in = AL;              // all channels idle, ch2 pin high
        mon_en    = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        n_reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_db_polarity", 32'(db_out), 32'd0);
        check("idle_any", 32'(any_pressed), 32'd0);

        // Active-low channel 2 and any_pressed
        set_level(2, 1'b1);
        c = cyc;
        push_exp(c + 1 + LAT, K_PRESS, 2);
        repeat (9) @(negedge clk);
        check("pol_db_before", 32'(db_out[2]), 32'd0);
        check("pol_any_before", 32'(any_pressed), 32'd0);
        repeat (1) @(negedge clk);
        check("pol_db_after", 32'(db_out[2]), 32'd1);
        repeat (1) @(negedge clk);
        check("pol_any_after", 32'(any_pressed), 32'd1);
        repeat (5) @(negedge clk);
        set_level(2, 1'b0);
        c = cyc;
        push_exp(c + 1 + LAT, K_REL, 2);
        repeat (11) @(negedge clk);
        check("pol_db_released", 32'(db_out[2]), 32'd0);
        check("pol_any_released", 32'(any_pressed), 32'd0);
        repeat (10) @(negedge clk);

        // Bounce on channel 1: 3-cycle toggles never qualify
        for (int s = 0; s < 10; s++) begin
            set_level(1, (s % 2) == 0);
            repeat (3) @(negedge clk);
        end
        set_level(1, 1'b1);
        c = cyc;
        push_exp(c + 1 + LAT, K_PRESS, 1);
        repeat (9) @(negedge clk);
        check("bounce_db_before", 32'(db_out[1]), 32'd0);
        repeat (1) @(negedge clk);
        check("bounce_db_after", 32'(db_out[1]), 32'd1);
        repeat (10) @(negedge clk);
        set_level(1, 1'b0);
        push_exp(cyc + 1 + LAT, K_REL, 1);
        repeat (20) @(negedge clk);

        // Table-driven press/hold/release vectors
        for (int i = 0; i < 10; i++) begin
            set_level(tbl[i].ch, tbl[i].level);
            t = cyc + 1;
            if (tbl[i].level) begin
                p = t + LAT;
                push_exp(p, K_PRESS, tbl[i].ch);
                if (tbl[i].exp_long) push_exp(p + LONG, K_LONG, tbl[i].ch);
                for (int r = 0; r < tbl[i].exp_reps; r++) begin
                    push_exp(p + LONG + REP * (r + 1), K_REP, tbl[i].ch);
                end
            end else begin
                push_exp(t + LAT, K_REL, tbl[i].ch);
            end
            repeat (tbl[i].hold) @(negedge clk);
            check("tbl_db", 32'(db_out[tbl[i].ch]), 32'(tbl[i].level));
            check("tbl_any", 32'(any_pressed), 32'(tbl[i].level));
        end
        repeat (10) @(negedge clk);

        // All channels pressed together, reset at db_cnt == 5
        button_in = 4'b1111 ^ AL;
        c = cyc;
        repeat (7) @(negedge clk);
        n_reset = 1'b1;
        repeat (1) @(negedge clk);
        check_all_zero("midreset");
        n_reset = 1'b0;
        c = cyc;
        for (int ch = 0; ch < 4; ch++) push_exp(c + 1 + LAT, K_PRESS, ch);
        repeat (9) @(negedge clk);
        check("midreset_db_before", 32'(db_out), 32'd0);
        repeat (1) @(negedge clk);
        check("midreset_db_after", 32'(db_out), 32'hF);
        repeat (5) @(negedge clk);
        button_in = AL;
        c = cyc;
        for (int ch = 0; ch < 4; ch++) push_exp(c + 1 + LAT, K_REL, ch);
        repeat (20) @(negedge clk);
        check("final_db", 32'(db_out), 32'd0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
